spi_master_tx: RTL



---
 rtl/spi_master_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: serialises host bytes MSB first onto sck/cs/mosi.
// Latency: cs falls the cycle after accept; 17*HALF_PERIOD+1 cycles per byte inside a frame.
// Backpressure: tx_ready only in IDLE/NEXT; NEXT stalls indefinitely with cs low, sck low.
// Optional build macro: SPI_MASTER_CS_PER_BYTE_EN (every byte closes its own cs frame).
module spi_master_tx #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_HOLD     = 8,
  parameter int CS_IDLE     = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_sck,
  output logic       o_cs,
  output logic       o_mosi
);

  localparam int MAX_A   = (HALF_PERIOD > CS_HOLD) ? HALF_PERIOD : CS_HOLD;
  localparam int MAX_CNT = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
  localparam int PW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [PW-1:0] HP_END   = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] HOLD_END = PW'(CS_HOLD - 1);
  localparam logic [PW-1:0] IDLE_END = PW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_TAIL,
    S_NEXT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_phase;
  logic [3:0]      r_bit_cnt;
  logic [6:0]      r_shift;    // bits still to be sent after the one on mosi
  logic            r_last;
  logic            r_sck;
  logic            r_cs;
  logic            r_mosi;
  logic            r_busy;
  logic            r_done;

  logic            w_accept;
  logic            w_last_in;

`ifdef SPI_MASTER_CS_PER_BYTE_EN
  // Every byte closes its frame; the host flag has no effect.
  assign w_last_in = i_tx_last | 1'b1;
`else
  assign w_last_in = i_tx_last;
`endif

  // Ready is a decode of the waiting states, forced low while reset is asserted.
  assign o_tx_ready = ((r_state == S_IDLE) || (r_state == S_NEXT)) && i_reset;
  assign w_accept   = o_tx_ready & i_tx_valid;

  assign o_sck  = r_sck;
  assign o_cs   = r_cs;
  assign o_mosi = r_mosi;
  assign o_busy = r_busy;
  assign o_done = r_done;

  // Frame/bit sequencer with all serial outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_bit_cnt <= 4'd0;
      r_shift   <= 7'd0;
      r_last    <= 1'b0;
      r_sck     <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_NEXT: begin
          if (w_accept) begin
            r_shift   <= i_tx_data[6:0];
            r_mosi    <= i_tx_data[7];
            r_last    <= w_last_in;
            r_cs      <= 1'b0;
            r_sck     <= 1'b0;
            r_phase   <= '0;
            r_bit_cnt <= 4'd0;
            r_busy    <= 1'b1;
            r_state   <= S_LOW;
          end
        end
        S_LOW: begin
          if (r_phase == HP_END) begin
            r_phase <= '0;
            r_sck   <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_HIGH: begin
          if (r_phase == HP_END) begin
            r_phase <= '0;
            r_sck   <= 1'b0;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= 4'd8;
              r_state   <= S_TAIL;
            end else begin
              // mosi moves with the falling edge so it is stable around each rise
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_mosi    <= r_shift[6];
              r_shift   <= {r_shift[5:0], 1'b0};
              r_state   <= S_LOW;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_TAIL: begin
          if (r_phase == HP_END) begin
            r_phase <= '0;
            r_state <= r_last ? S_HOLD : S_NEXT;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_phase == HOLD_END) begin
            r_phase <= '0;
            r_cs    <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_GAP: begin
          if (r_phase == IDLE_END) begin
            r_phase <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sck   <= 1'b0;
          r_cs    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
